// File: rtl/power_pkg.sv
// Shared definitions for the power_of_number unit: FSM state encoding,
// default operand width and the iteration-counter width helper.
package power_pkg;

    localparam int DEFAULT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ   = 2'd1,
        ST_CB   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter must index W multiplier bits; never collapse to zero width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_W);

endpackage

// File: rtl/shift_add_mult_step.sv
// One shift-add multiplier step: adds (multiplicand << shamt) to the
// accumulator when the current multiplier bit is set. Purely combinational.
module shift_add_mult_step
    import power_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = cnt_width(W)
) (
    input  logic [3*W-1:0]   acc,
    input  logic [2*W-1:0]   mcand,
    input  logic             mbit,
    input  logic [CNT_W-1:0] shamt,
    output logic [3*W-1:0]   acc_next
);

    logic [3*W-1:0] partial;

    always_comb begin
        // Shift at full 3*W width so no partial-product bits are lost.
        partial  = {{W{1'b0}}, mcand} << shamt;
        acc_next = mbit ? (acc + partial) : acc;
    end

endmodule

// File: rtl/power_of_number.sv
// Sequential power unit: num -> num^2 and num^3 using one shared shift-add
// step over two W-cycle phases, with valid/ready handshakes on both sides.
module power_of_number
    import power_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   num,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] sq,
    output logic [3*W-1:0] cb,
    output logic           busy
);

    localparam int               CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     num_q,   num_d;
    logic [2*W-1:0]   a_q,     a_d;
    logic [W-1:0]     m_q,     m_d;
    logic [3*W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2*W-1:0]   sq_q,    sq_d;
    logic [3*W-1:0]   cb_q,    cb_d;
    logic [3*W-1:0]   acc_step;

    shift_add_mult_step #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_step (
        .acc      (acc_q),
        .mcand    (a_q),
        .mbit     (m_q[0]),
        .shamt    (cnt_q),
        .acc_next (acc_step)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        num_d   = num_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        cb_d    = cb_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    num_d   = num;
                    a_d     = {{W{1'b0}}, num};
                    m_d     = num;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SQ;
                end
            end

            ST_SQ, ST_CB: begin
                acc_d = acc_step;
                m_d   = m_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (state_q == ST_SQ) begin
                        // Square becomes the multiplicand of the cube phase.
                        sq_d    = acc_step[2*W-1:0];
                        a_d     = acc_step[2*W-1:0];
                        m_d     = num_q;
                        state_d = ST_CB;
                    end else begin
                        cb_d    = acc_step;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= '0;
            cb_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state_q <= state_d;
            num_q   <= num_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            cb_q    <= cb_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SQ) || (state_q == ST_CB);
    assign sq        = sq_q;
    assign cb        = cb_q;

endmodule

// File: tb/tb_power_of_number.sv
// Scoreboard bench for power_of_number: accepted operands push expected
// powers; a negedge monitor pops and compares results, latency and roots.
module tb_power_of_number;

    localparam int W       = 16;
    localparam int LATENCY = 2 * W;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   num;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] sq;
    logic [3*W-1:0] cb;
    logic           busy;

    power_of_number #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sq        (sq),
        .cb        (cb),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint unsigned n;
        longint unsigned sq;
        longint unsigned cb;
        longint          acc_edge;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    logic   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference roots: largest r with r^2 <= x, largest r with r^3 <= x.
    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned lo = 0, hi = 65536, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid; else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic longint unsigned icbrt(input longint unsigned x);
        longint unsigned lo = 0, hi = 65536, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid * mid <= x) lo = mid; else hi = mid - 1;
        end
        return lo;
    endfunction

    // Monitor and acceptance tracker share one process to keep queue order deterministic.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
                else check("latency", 64'(cyc - sb[0].acc_edge), 64'(LATENCY));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sq", 64'(sq), e.sq);
                check("cb", 64'(cb), e.cb);
                check("sqrt_loop", isqrt(64'(sq)), e.n);
                check("cbrt_loop", icbrt(64'(cb)), e.n);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.n        = 64'(num);
                e.sq       = e.n * e.n;
                e.cb       = e.n * e.n * e.n;
                e.acc_edge = cyc + 1;
                sb.push_back(e);
            end
            prev_valid <= out_valid;
        end
    end

    // Present num until accepted, then drop in_valid; checks busy after accept.
    task automatic send(input logic [W-1:0] n);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        num      = n;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        num      = $urandom();
        @(negedge clk);
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_when_busy", 64'(in_ready), 64'd0);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && in_ready) ok = 1;
        end
        if (!ok) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] hold_sq;
        logic [3*W-1:0] hold_cb;
        bit             seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        num       = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sq", 64'(sq), 64'd0);
        check("rst_cb", 64'(cb), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed values, including the all-ones width boundary.
        send(16'd0);     drain();
        send(16'd3);     drain();
        send(16'd1000);  drain();
        send(16'hFFFF);  drain();
        check("max_cb_exact", 64'(cb), 64'd281462092005375);

        // Back-pressure: results hold while out_ready is low; in_valid meanwhile is ignored.
        out_ready = 1'b0;
        send(16'd11);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("hold_reached_done", 64'(seen), 64'd1);
        hold_sq  = sq;
        hold_cb  = cb;
        @(posedge clk); #1;
        in_valid = 1'b1;
        num      = 16'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_sq", 64'(sq), 64'(hold_sq));
            check("hold_cb", 64'(cb), 64'(hold_cb));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        // Handshake-out edge must not also accept the pending operand.
        check("no_bypass_in_ready", 64'(in_ready), 64'd0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1;
        end
        check("back_to_idle", 64'(seen), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of an operation abandons it without output.
        send(16'd5);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        send(16'd5);  drain();

        // Random operands closing the loop through the reference roots.
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom()));
            if ($urandom_range(0, 1) == 1) begin
                repeat (LATENCY + 2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            drain();
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
